rng_entropy_packer: RTL



---
 rtl/rng_pkg.sv | 7 +
 rtl/rng_word_fifo.sv | 74 +++++++
 rtl/rng_entropy_packer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared widths and debias state type for the RNG entropy packer
package rng_pkg;
  localparam int RNG_WORD_W = 32;
  localparam int RNG_OVF_W  = 16;

  typedef enum logic {IDLE, HAVE_FIRST} debias_state_t;
endpackage

// File: rtl/rng_word_fifo.sv
// rtl/rng_word_fifo.sv - word FIFO with registered output and valid/ready read side
// Capacity counts the output register, so P_DEPTH words total can be held.
module rng_word_fifo
  import rng_pkg::*;
#(
  parameter int P_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [RNG_WORD_W-1:0] push_data,
  output logic                  full,
  output logic                  push_ok,
  output logic [RNG_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [RNG_WORD_W-1:0] mem [P_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         mem_cnt;
  logic [CW-1:0]         total;
  logic                  pop;
  logic                  load;
  logic                  from_mem;
  logic                  bypass;
  logic                  to_mem;

  assign pop      = out_valid & out_ready;
  assign total    = mem_cnt + CW'(out_valid);
  assign full     = (total == CW'(P_DEPTH));
  assign push_ok  = push & (~full | pop);
  assign load     = ~out_valid | pop;
  assign from_mem = load & (mem_cnt != '0);
  // An empty store lets the pushed word go straight into the output register.
  assign bypass   = load & (mem_cnt == '0) & push_ok;
  assign to_mem   = push_ok & ~bypass;

  always_ff @(posedge clk) begin
    if (to_mem) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (to_mem) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (from_mem) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_cnt <= mem_cnt + CW'(to_mem) - CW'(from_mem);
      if (from_mem) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_data  <= push_data;
        out_valid <= 1'b1;
      end else if (load) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rng_entropy_packer.sv
// rtl/rng_entropy_packer.sv - ADC LSB entropy extractor, health test and 32-bit word packer
// Optional von Neumann debiasing is built when RNG_VN_DEBIAS_EN is defined.
module rng_entropy_packer
  import rng_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 8,
  parameter int P_REP_LIMIT  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [13:0]           ada_d,
  input  logic [13:0]           adb_d,
  input  logic                  ad_or,
  input  logic                  sample_valid,
  output logic [RNG_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  health_fail,
  output logic [RNG_OVF_W-1:0]  overflow_cnt
);
  logic                  raw_bit;
  logic                  raw_take;
  logic                  ovr_take;
  logic                  emit;
  logic                  emit_bit;
  logic [7:0]            rep_cnt;
  logic [7:0]            rep_next;
  logic                  prev_bit;
  logic [4:0]            pack_cnt;
  logic [RNG_WORD_W-1:0] shift_word;
  logic [RNG_WORD_W-1:0] word;
  logic                  word_vld;
  logic                  fifo_full;
  logic                  push_ok;
  logic                  drop;
  logic                  unused_bits;

  assign unused_bits = ^{ada_d[13:1], adb_d[13:1]};
  assign raw_bit     = ada_d[0] ^ adb_d[0];
  assign raw_take    = sample_valid & ~ad_or;
  assign ovr_take    = sample_valid & ad_or;

  always_comb begin
    rep_next = 8'd1;
    if (rep_cnt != 8'd0 && raw_bit == prev_bit) begin
      rep_next = (rep_cnt == 8'hFF) ? 8'hFF : rep_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt     <= 8'd0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (raw_take) begin
      rep_cnt  <= rep_next;
      prev_bit <= raw_bit;
      if (rep_next == 8'(P_REP_LIMIT)) begin
        health_fail <= 1'b1;
      end
    end
  end

`ifdef RNG_VN_DEBIAS_EN
  debias_state_t state;
  logic          first_bit;

  // Pair 10 emits 1 and pair 01 emits 0, i.e. the first bit of an unequal pair.
  assign emit     = raw_take & (state == HAVE_FIRST) & (first_bit != raw_bit) & ~health_fail;
  assign emit_bit = first_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      first_bit <= 1'b0;
    end else if (ovr_take) begin
      state <= IDLE;
    end else if (raw_take) begin
      case (state)
        IDLE: begin
          first_bit <= raw_bit;
          state     <= HAVE_FIRST;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_ovr;

  assign unused_ovr = ovr_take;
  assign emit       = raw_take & ~health_fail;
  assign emit_bit   = raw_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_cnt   <= 5'd0;
      shift_word <= '0;
      word       <= '0;
      word_vld   <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (emit) begin
        shift_word[pack_cnt] <= emit_bit;
        pack_cnt             <= pack_cnt + 5'd1;
        if (pack_cnt == 5'd31) begin
          word     <= {emit_bit, shift_word[30:0]};
          word_vld <= 1'b1;
        end
      end
    end
  end

  rng_word_fifo #(
    .P_DEPTH(P_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_vld),
    .push_data (word),
    .full      (fifo_full),
    .push_ok   (push_ok),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign drop = word_vld & fifo_full & ~push_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (drop && overflow_cnt != '1) begin
      overflow_cnt <= overflow_cnt + 1'b1;
    end
  end
endmodule
